cpu_bus_responder: RTL and testbench
====================================

# cpu_bus_responder

Memory-side responder for the 4-bit CPU's nibble bus. It decodes each bus cycle from the CPU (instruction fetch, data load, data store) and drives the requested read nibble back within the same cycle. Stores are committed at the clock edge. It also owns a program loader that holds the CPU in reset while a nibble stream fills program memory. It sits in the top level beside the CPU: the CPU's dedicated outputs and upper IO outputs feed it, and its read data feeds the CPU's IO inputs.

## Interface

- PROG_WORDS, 16, program memory depth in 12-bit instruction words. Power of two, 2..1024.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- bus_addr  in  8  CPU address byte (PC[9:2] on fetch, zero-extended data address on load/store)
- bus_ctl  in  4  CPU control nibble: [3:2] = PC[1:0] or access class, [1:0] = phase
- bus_wdata  in  4  CPU store data
- bus_rdata  out  4  read nibble to CPU, combinational
- cpu_rst  out  1  active-high CPU hold; top level inverts it for the CPU's active-low reset
- prog_data  in  4  loader nibble
- prog_valid  in  1  loader nibble valid
- prog_ready  out  1  loader ready
- prog_done  in  1  loader early-finish strobe
- prog_start  in  1  re-enter loading from RUN
- bus_err  out  1  sticky illegal-cycle flag

## Operation

- Storage:
  - Program memory: PROG_WORDS x 12 bits. Nibble k of a word is bits [4k+3:4k].
  - Data RAM: 16 x 4 bits.
- States:
  - LOADING: reset state.
  - RUN
- rst: state = LOADING, load pointer = 0, both memories = 0, bus_err = 0.
- LOADING:
  - cpu_rst = 1, prog_ready = 1 (0 while rst is high).
  - Each cycle with prog_valid & prog_ready, prog_data is written to nibble (ptr mod 3) of word (ptr / 3), and ptr increments.
  - The accept at ptr = 3*PROG_WORDS-1, or prog_done high in any LOADING cycle, moves the state to RUN. A nibble accepted in the same cycle as prog_done is written first.
  - Unloaded words keep their prior contents.
  - Bus is ignored: bus_rdata = 0, no stores, no errors.
- RUN:
  - cpu_rst = 0, prog_ready = 0, prog_valid ignored.
  - prog_start moves the state to LOADING with ptr = 0 and asserts cpu_rst. A bus store in that same cycle is suppressed. Program memory is not cleared; data RAM is not cleared.
- Bus decode in RUN, with phase = bus_ctl[1:0]:
  - phase 00/01/10 (fetch): word index = {bus_addr, bus_ctl[3:2]} mod PROG_WORDS, so upper bits wrap. bus_rdata = nibble phase of that word.
  - phase 11, bus_ctl[3:2] = 01 (load): bus_rdata = dram[bus_addr[3:0]].
  - phase 11, bus_ctl[3:2] = 00 (store): dram[bus_addr[3:0]] is written with bus_wdata at the edge. bus_rdata = 0.
  - phase 11, bus_ctl[3:2] = 1x: illegal. bus_rdata = 0, no write, bus_err set at the edge.
  - bus_addr[7:4] is ignored on load and store.
- bus_err stays set until rst, or until the edge on which prog_start is taken.

## Timing

- bus_rdata is purely combinational from bus_addr, bus_ctl, state and memory; zero cycles of latency. The CPU samples it on the same edge.
- A store is visible to a load on the next cycle. There is no read-during-write case, since the bus is single-ported with one access per cycle.
- Program nibble accepted at edge N is readable by a fetch from cycle N+1.
- Last nibble, or prog_done, at edge N: RUN from cycle N+1, with cpu_rst low in that cycle.
- prog_start at edge N: cpu_rst = 1 and prog_ready = 1 from cycle N+1.
- Reset values:
  - bus_rdata = 0, cpu_rst = 1, prog_ready = 0, bus_err = 0.
  - prog_ready rises in the first cycle after rst falls.
- rst mid-load or mid-run: aborts immediately. Partial loads are discarded because memories clear.

## Test plan

- **Full load and fetch.** After rst, load 48 nibbles with value = index mod 16 (PROG_WORDS = 16).
  - During the load, prog_ready = 1 and cpu_rst = 1.
  - Cycle after the 48th accept: cpu_rst = 0 and prog_ready = 0.
  - Fetch with bus_addr = 0x01 and bus_ctl = 0100/0101/0110 -> bus_rdata = F, 0, 1 (word 5).
- **Store/load.** In RUN, bus_addr = 0x07, bus_ctl = 0011, bus_wdata = A.
  - Next cycle, bus_ctl = 0111 -> bus_rdata = A.
  - Load from bus_addr = 0x17 -> A (upper address bits ignored).
  - Load from 0x06 -> 0.
- **Wrap.** With the pattern loaded, fetch with bus_addr = 0x05, bus_ctl[3:2] = 01 (word 21) -> same nibbles as word 5 (F, 0, 1).
- **Illegal cycle.** bus_ctl = 1011 with bus_wdata = 5 at bus_addr = 0x02 -> bus_rdata = 0 that cycle. bus_err = 1 from the next cycle and stays 1 through later legal cycles. dram[2] is unchanged.
- **Reload mid-run.**
  - prog_start in the same cycle as a store of 9 to address 3 -> dram[3] is unchanged and cpu_rst = 1 next cycle.
  - Then load nibbles 1, 2, 3 with prog_done on the third -> word 0 reads 1/2/3 and word 1 keeps its old value.
  - bus_err = 0.
- **Reset mid-load.** After 10 accepted nibbles, pulse rst.
  - During rst: prog_ready = 0.
  - After rst: ptr restarts at 0, and once RUN is reached via prog_done, every fetch and every load returns 0.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 4-bit CPU nibble bus: program memory, data RAM and
// a nibble-stream program loader that holds the CPU in reset while it fills memory.
module cpu_bus_responder #(
    parameter int unsigned PROG_WORDS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] bus_addr_i,
    input  logic [3:0] bus_ctl_i,
    input  logic [3:0] bus_wdata_i,
    output logic [3:0] bus_rdata_o,
    output logic       cpu_rst_o,
    input  logic [3:0] prog_data_i,
    input  logic       prog_valid_i,
    output logic       prog_ready_o,
    input  logic       prog_done_i,
    input  logic       prog_start_i,
    output logic       bus_err_o
);

    localparam int unsigned AW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;

    typedef enum logic [0:0] {StLoading, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   word_q, word_d;
    logic [1:0]      nib_q, nib_d;
    logic            err_q, err_d;
    logic            pm_we, dm_we;
    logic [11:0]     pmem_q [PROG_WORDS];
    logic [3:0]      dram_q [16];

    logic [1:0]      phase;
    logic [1:0]      cls;
    logic [AW-1:0]   fetch_idx;
    logic [11:0]     fetch_word;
    logic            last_nib;

    assign phase      = bus_ctl_i[1:0];
    assign cls        = bus_ctl_i[3:2];
    // Upper word-index bits beyond the memory depth simply wrap.
    assign fetch_idx  = AW'({bus_addr_i, bus_ctl_i[3:2]});
    assign fetch_word = pmem_q[fetch_idx];
    assign last_nib   = (word_q == AW'(PROG_WORDS - 1)) && (nib_q == 2'd2);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        nib_d   = nib_q;
        err_d   = err_q;
        pm_we   = 1'b0;
        dm_we   = 1'b0;
        case (state_q)
            StLoading: begin
                if (prog_valid_i) begin
                    pm_we = 1'b1;
                    if (nib_q == 2'd2) begin
                        nib_d  = 2'd0;
                        word_d = word_q + 1'b1;
                    end else begin
                        nib_d = nib_q + 2'd1;
                    end
                    if (last_nib) begin
                        state_d = StRun;
                    end
                end
                if (prog_done_i) begin
                    state_d = StRun;
                end
            end
            default: begin
                if (prog_start_i) begin
                    state_d = StLoading;
                    word_d  = '0;
                    nib_d   = 2'd0;
                    err_d   = 1'b0;
                end else if (phase == 2'b11) begin
                    if (cls[1]) begin
                        err_d = 1'b1;
                    end else if (!cls[0]) begin
                        dm_we = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus_rdata_o = 4'h0;
        if (state_q == StRun) begin
            if (phase != 2'b11) begin
                case (phase)
                    2'b00:   bus_rdata_o = fetch_word[3:0];
                    2'b01:   bus_rdata_o = fetch_word[7:4];
                    default: bus_rdata_o = fetch_word[11:8];
                endcase
            end else if (cls == 2'b01) begin
                bus_rdata_o = dram_q[bus_addr_i[3:0]];
            end
        end
    end

    assign cpu_rst_o    = (state_q == StLoading);
    assign prog_ready_o = (state_q == StLoading) && !rst_i;
    assign bus_err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StLoading;
            word_q  <= '0;
            nib_q   <= 2'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(PROG_WORDS); i++) begin
                pmem_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                dram_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
            err_q   <= err_d;
            if (pm_we) begin
                case (nib_q)
                    2'd0:    pmem_q[word_q][3:0]  <= prog_data_i;
                    2'd1:    pmem_q[word_q][7:4]  <= prog_data_i;
                    default: pmem_q[word_q][11:8] <= prog_data_i;
                endcase
            end
            if (dm_we) begin
                dram_q[bus_addr_i[3:0]] <= bus_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_cpu_bus_responder;

    logic       clk;
    logic       rst;
    logic [7:0] bus_addr;
    logic [3:0] bus_ctl;
    logic [3:0] bus_wdata;
    logic [3:0] bus_rdata;
    logic       cpu_rst;
    logic [3:0] prog_data;
    logic       prog_valid;
    logic       prog_ready;
    logic       prog_done;
    logic       prog_start;
    logic       bus_err;

    cpu_bus_responder #(.PROG_WORDS(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus_addr_i  (bus_addr),
        .bus_ctl_i   (bus_ctl),
        .bus_wdata_i (bus_wdata),
        .bus_rdata_o (bus_rdata),
        .cpu_rst_o   (cpu_rst),
        .prog_data_i (prog_data),
        .prog_valid_i(prog_valid),
        .prog_ready_o(prog_ready),
        .prog_done_i (prog_done),
        .prog_start_i(prog_start),
        .bus_err_o   (bus_err)
    );

    localparam int SigRdata = 0;
    localparam int SigCpuRst = 1;
    localparam int SigReady = 2;
    localparam int SigErr = 3;

    typedef struct {
        string      name;
        int         cyc;
        int         sig;
        logic [3:0] val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int sig, input logic [3:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = v;
        q.push_back(e);
    endtask

    // Monitor: outputs are always presented, so compare everything due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] act;
            e = q.pop_front();
            case (e.sig)
                SigRdata:  act = bus_rdata;
                SigCpuRst: act = {3'b000, cpu_rst};
                SigReady:  act = {3'b000, prog_ready};
                default:   act = {3'b000, bus_err};
            endcase
            n_checks++;
            if (e.cyc != cyc) begin
                n_errors++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [7:0] a, input logic [3:0] c, input logic [3:0] w);
        bus_addr  = a;
        bus_ctl   = c;
        bus_wdata = w;
    endtask

    initial begin
        rst = 1'b1;
        prog_data = 4'h0;
        prog_valid = 1'b0;
        prog_done = 1'b0;
        prog_start = 1'b0;
        bus(8'h00, 4'h0, 4'h0);
        #1;
        step();
        chk("rst_cpu_rst", SigCpuRst, 4'h1);
        chk("rst_ready", SigReady, 4'h0);
        chk("rst_rdata", SigRdata, 4'h0);
        chk("rst_err", SigErr, 4'h0);
        step();

        // Full load: nibble i = i mod 16
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            prog_valid = 1'b1;
            prog_data  = 4'(i % 16);
            if (i == 0 || i == 20 || i == 47) begin
                chk("load_ready", SigReady, 4'h1);
                chk("load_cpu_rst", SigCpuRst, 4'h1);
            end
            if (i == 10) begin
                bus(8'h01, 4'b0100, 4'h0);
                chk("load_bus_ignored", SigRdata, 4'h0);
            end
            step();
        end
        prog_valid = 1'b0;
        chk("run_cpu_rst", SigCpuRst, 4'h0);
        chk("run_ready", SigReady, 4'h0);
        chk("fetch_w5_n0", SigRdata, 4'hF);
        step();
        bus(8'h01, 4'b0101, 4'h0); chk("fetch_w5_n1", SigRdata, 4'h0); step();
        bus(8'h01, 4'b0110, 4'h0); chk("fetch_w5_n2", SigRdata, 4'h1); step();
        bus(8'h00, 4'b0010, 4'h0); chk("fetch_w0_n2", SigRdata, 4'h2); step();
        bus(8'h03, 4'b1110, 4'h0); chk("fetch_w15_n2", SigRdata, 4'hF); step();
        // Word 21 wraps to word 5
        bus(8'h05, 4'b0100, 4'h0); chk("wrap_n0", SigRdata, 4'hF); step();
        bus(8'h05, 4'b0101, 4'h0); chk("wrap_n1", SigRdata, 4'h0); step();
        bus(8'h05, 4'b0110, 4'h0); chk("wrap_n2", SigRdata, 4'h1); step();

        // Store / load
        bus(8'h07, 4'b0011, 4'hA); chk("store_rdata", SigRdata, 4'h0); step();
        bus(8'h07, 4'b0111, 4'h0); chk("load_07", SigRdata, 4'hA); step();
        bus(8'h17, 4'b0111, 4'h0); chk("load_17", SigRdata, 4'hA); step();
        bus(8'h06, 4'b0111, 4'h0); chk("load_06", SigRdata, 4'h0); step();

        // Illegal cycle
        bus(8'h02, 4'b1011, 4'h5);
        chk("illegal_rdata", SigRdata, 4'h0);
        chk("illegal_err_before", SigErr, 4'h0);
        step();
        bus(8'h02, 4'b0111, 4'h0);
        chk("illegal_dram2", SigRdata, 4'h0);
        chk("illegal_err_set", SigErr, 4'h1);
        step();
        bus(8'h01, 4'b0100, 4'h0);
        chk("illegal_err_sticky", SigErr, 4'h1);
        step();

        // Reload mid-run, store in the same cycle is suppressed
        bus(8'h03, 4'b0011, 4'h9);
        prog_start = 1'b1;
        chk("reload_cpu_rst_before", SigCpuRst, 4'h0);
        step();
        prog_start = 1'b0;
        bus(8'h03, 4'b0111, 4'h0);
        chk("reload_cpu_rst", SigCpuRst, 4'h1);
        chk("reload_ready", SigReady, 4'h1);
        chk("reload_err_clr", SigErr, 4'h0);
        chk("reload_bus_ignored", SigRdata, 4'h0);
        for (int i = 1; i <= 3; i++) begin
            prog_valid = 1'b1;
            prog_data  = 4'(i);
            prog_done  = (i == 3);
            step();
        end
        prog_valid = 1'b0;
        prog_done  = 1'b0;
        bus(8'h03, 4'b0111, 4'h0);
        chk("reload_run", SigCpuRst, 4'h0);
        chk("reload_store_supp", SigRdata, 4'h0);
        chk("reload_err", SigErr, 4'h0);
        step();
        bus(8'h07, 4'b0111, 4'h0); chk("reload_dram_kept", SigRdata, 4'hA); step();
        bus(8'h00, 4'b0000, 4'h0); chk("reload_w0_n0", SigRdata, 4'h1); step();
        bus(8'h00, 4'b0001, 4'h0); chk("reload_w0_n1", SigRdata, 4'h2); step();
        bus(8'h00, 4'b0010, 4'h0); chk("reload_w0_n2", SigRdata, 4'h3); step();
        bus(8'h00, 4'b0100, 4'h0); chk("reload_w1_n0", SigRdata, 4'h3); step();
        bus(8'h00, 4'b0101, 4'h0); chk("reload_w1_n1", SigRdata, 4'h4); step();
        bus(8'h00, 4'b0110, 4'h0); chk("reload_w1_n2", SigRdata, 4'h5); step();

        // Reset mid-load
        prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            prog_valid = 1'b1;
            prog_data  = 4'h7;
            step();
        end
        prog_valid = 1'b0;
        rst = 1'b1;
        chk("midrst_ready", SigReady, 4'h0);
        chk("midrst_cpu_rst", SigCpuRst, 4'h1);
        step();
        rst = 1'b0;
        chk("midrst_ready_after", SigReady, 4'h1);
        prog_done = 1'b1;
        step();
        prog_done = 1'b0;
        bus(8'h00, 4'b0000, 4'h0);
        chk("midrst_run", SigCpuRst, 4'h0);
        chk("midrst_w0", SigRdata, 4'h0);
        step();
        bus(8'h01, 4'b0100, 4'h0); chk("midrst_w5", SigRdata, 4'h0); step();
        bus(8'h00, 4'b1110, 4'h0); chk("midrst_w3_n2", SigRdata, 4'h0); step();
        bus(8'h07, 4'b0111, 4'h0); chk("midrst_dram7", SigRdata, 4'h0); step();

        // Pointer restarted at 0: a single nibble lands in word 0 nibble 0
        prog_start = 1'b1;
        step();
        prog_start = 1'b0;
        prog_valid = 1'b1;
        prog_data  = 4'hC;
        prog_done  = 1'b1;
        step();
        prog_valid = 1'b0;
        prog_done  = 1'b0;
        bus(8'h00, 4'b0000, 4'h0); chk("ptr0_w0_n0", SigRdata, 4'hC); step();
        bus(8'h00, 4'b0001, 4'h0); chk("ptr0_w0_n1", SigRdata, 4'h0); step();

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            n_errors += q.size();
            n_checks += q.size();
            $display("FAIL drain: %0d checks never compared, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
